icache_axi_dm: RTL and testbench

Direct-mapped, read-only instruction cache between the IF stage and an AXI4 read-only master port. It generalises the single-entry fetch buffer to NUM_LINES lines of LINE_WORDS words, refilled by one AXI4 INCR burst per miss. Hits return the instruction combinationally with no stall. It also adds whole-cache invalidate (fence.i), bus-error reporting and hit/miss counters.

---
 rtl/icache_axi_dm.sv | 201 ++++++++++++++++++++
 tb/tb_icache_axi_dm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_dm.sv
// Direct-mapped read-only instruction cache with AXI4 INCR-burst line refill.
// Hits are combinational; misses stall IF until the whole line has been fetched.
module icache_axi_dm #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic [31:0] inst,
    output logic        stall_out,
    input  logic        flush,
    output logic        fetch_err,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    localparam int OFF_W   = $clog2(LINE_WORDS);
    localparam int IDX_W   = $clog2(NUM_LINES);
    localparam int TAG_W   = 30 - OFF_W - IDX_W;
    localparam int CNT_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam int ENTRIES = NUM_LINES * LINE_WORDS;
    localparam int FLAT_W  = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [31:0]          r_data [ENTRIES];

    logic [31:0]          r_araddr;
    logic [IDX_W-1:0]     r_line;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 r_flush_pend;
    logic                 r_fetch_err;
    logic [31:0]          r_hit_count;
    logic [31:0]          r_miss_count;

    logic [IDX_W-1:0]     w_idx;
    logic [CNT_W-1:0]     w_off;
    logic [TAG_W-1:0]     w_tag;
    logic [FLAT_W-1:0]    w_rd_ptr;
    logic [FLAT_W-1:0]    w_wr_ptr;
    logic                 w_hit;
    logic                 w_start;
    logic                 w_beat;
    logic                 w_last;
    logic                 w_err_final;
    logic                 w_flush_final;

    // Offset width may be zero for single-word lines, so fields are extracted by shifting.
    assign w_idx    = IDX_W'(addr >> (2 + OFF_W));
    assign w_off    = (LINE_WORDS > 1) ? CNT_W'(addr >> 2) : '0;
    assign w_tag    = TAG_W'(addr >> (2 + OFF_W + IDX_W));
    assign w_rd_ptr = FLAT_W'(int'(w_idx) * LINE_WORDS + int'(w_off));
    assign w_wr_ptr = FLAT_W'(int'(r_line) * LINE_WORDS + int'(r_cnt));

    assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign inst      = w_hit ? r_data[w_rd_ptr] : '0;
    assign stall_out = !w_hit;

    assign w_err_final   = r_err | (m_axi_rresp != 2'b00);
    assign w_flush_final = r_flush_pend | flush;

    assign m_axi_araddr  = r_araddr;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign fetch_err     = r_fetch_err;
    assign hit_count     = r_hit_count;
    assign miss_count    = r_miss_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        w_start       = 1'b0;
        w_beat        = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_hit && !flush) begin
                    w_start      = 1'b1;
                    w_state_next = S_AR;
                end
            end
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    w_state_next = S_R;
                end
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    w_beat = 1'b1;
                    if (r_cnt == CNT_W'(LINE_WORDS - 1)) begin
                        w_last       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_araddr     <= '0;
            r_line       <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_flush_pend <= 1'b0;
            r_fetch_err  <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            r_fetch_err <= w_last && w_err_final;
            if (w_hit) begin
                r_hit_count <= r_hit_count + 32'd1;
            end
            if (w_start) begin
                r_miss_count <= r_miss_count + 32'd1;
                r_araddr     <= addr & ~32'(LINE_WORDS * 4 - 1);
                r_line       <= w_idx;
                r_err        <= 1'b0;
                r_flush_pend <= 1'b0;
            end
            if (r_state == S_AR && m_axi_arready) begin
                r_cnt <= '0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_err <= w_err_final;
            end
            if (r_state != S_IDLE && flush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_last) begin
                r_err        <= 1'b0;
                r_flush_pend <= 1'b0;
            end
        end
    end

    // A completing refill sees flushes from earlier cycles and from this one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (r_state == S_IDLE && flush) begin
                r_valid <= '0;
            end else if (w_start) begin
                r_valid[w_idx] <= 1'b0;
            end
            if (w_last) begin
                if (w_flush_final) begin
                    r_valid <= '0;
                end else if (!w_err_final) begin
                    r_valid[r_line] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_tag[w_idx] <= w_tag;
        end
        if (w_beat) begin
            r_data[w_wr_ptr] <= m_axi_rdata;
        end
    end

endmodule

// File: tb/tb_icache_axi_dm.sv
// Directed bench for icache_axi_dm with a behavioural AXI read slave (NUM_LINES=4, LINE_WORDS=4).
// Slave memory word at byte address a is {16'hC0DE, a[15:0]}.
module tb_icache_axi_dm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        stall_out;
    logic        flush;
    logic        fetch_err;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int n_cmp = 0;
    int n_bad = 0;

    int          ar_delay = 0;
    int          r_gap    = 0;
    int          err_beat = -1;
    int          sl_state = 0;
    int          sl_wait  = 0;
    int          sl_cnt   = 0;
    int          sl_gapc  = 0;
    logic [31:0] sl_base  = '0;
    bit          sl_bad   = 1'b0;

    always #5 clk = ~clk;

    icache_axi_dm #(
        .NUM_LINES (4),
        .LINE_WORDS(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .inst         (inst),
        .stall_out    (stall_out),
        .flush        (flush),
        .fetch_err    (fetch_err),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
        .m_axi_araddr (m_axi_araddr),
        .m_axi_arlen  (m_axi_arlen),
        .m_axi_arsize (m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready),
        .m_axi_rdata  (m_axi_rdata),
        .m_axi_rresp  (m_axi_rresp),
        .m_axi_rvalid (m_axi_rvalid),
        .m_axi_rready (m_axi_rready)
    );

    // Slave acts 2 time units after each falling edge, once the main process has driven its inputs.
    initial begin
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        forever begin
            @(negedge clk);
            #2;
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_axi_rresp   = 2'b00;
            if (rst === 1'b1) begin
                sl_state = 0;
            end else begin
                if (sl_state == 0 && m_axi_arvalid === 1'b1) begin
                    sl_base  = m_axi_araddr;
                    sl_wait  = ar_delay;
                    sl_state = 1;
                end
                if (sl_state == 1) begin
                    if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== sl_base) sl_bad = 1'b1;
                    if (sl_wait == 0) begin
                        m_axi_arready = 1'b1;
                        sl_state      = 2;
                        sl_cnt        = 0;
                        sl_gapc       = r_gap;
                    end else begin
                        sl_wait--;
                    end
                end else if (sl_state == 2) begin
                    if (sl_gapc > 0) begin
                        sl_gapc--;
                    end else begin
                        m_axi_rvalid = 1'b1;
                        m_axi_rdata  = {16'hC0DE, sl_base[15:0] + 16'(4 * sl_cnt)};
                        m_axi_rresp  = (sl_cnt == err_beat) ? 2'b10 : 2'b00;
                        sl_cnt++;
                        sl_gapc = r_gap;
                        if (sl_cnt == 4) sl_state = 0;
                    end
                end
            end
        end
    end

    task automatic wait_fill(output int cycles);
        cycles = 0;
        while (stall_out === 1'b1 && cycles < 40) begin
            @(negedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; addr = 32'h100; flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL reset_stall: got %b want 1", stall_out); end
        n_cmp++; if (inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 0", inst); end
        n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid: got %b want 0", m_axi_arvalid); end
        n_cmp++; if (m_axi_rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready: got %b want 0", m_axi_rready); end
        n_cmp++; if (m_axi_araddr !== 32'h0) begin n_bad++; $display("FAIL reset_araddr: got %h want 0", m_axi_araddr); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("FAIL reset_fetch_err: got %b want 0", fetch_err); end
        n_cmp++; if (hit_count !== 32'd0) begin n_bad++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
        n_cmp++; if (miss_count !== 32'd0) begin n_bad++; $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
    endtask

    task automatic test_first_miss();
        int c;
        @(negedge clk); rst = 1'b0; addr = 32'h100; #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL miss_stall: got %b want 1", stall_out); end
        @(negedge clk); #1;
        n_cmp++; if (m_axi_arvalid !== 1'b1) begin n_bad++; $display("FAIL first_arvalid: got %b want 1", m_axi_arvalid); end
        n_cmp++; if (m_axi_araddr !== 32'h100) begin n_bad++; $display("FAIL first_araddr: got %h want 100", m_axi_araddr); end
        n_cmp++; if (m_axi_arlen !== 8'd3) begin n_bad++; $display("FAIL arlen: got %0d want 3", m_axi_arlen); end
        n_cmp++; if (m_axi_arsize !== 3'b010) begin n_bad++; $display("FAIL arsize: got %b want 010", m_axi_arsize); end
        n_cmp++; if (m_axi_arburst !== 2'b01) begin n_bad++; $display("FAIL arburst: got %b want 01", m_axi_arburst); end
        wait_fill(c);
        n_cmp++; if (c + 1 != 6) begin n_bad++; $display("FAIL first_latency: got %0d want 6", c + 1); end
        n_cmp++; if (inst !== 32'hC0DE0100) begin n_bad++; $display("FAIL first_inst: got %h want C0DE0100", inst); end
        n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL first_miss_count: got %0d want 1", miss_count); end
    endtask

    task automatic test_hit_sweep();
        int c;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); addr = 32'h100 + 32'(4 * i); #1;
            n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL sweep_stall[%0d]: got %b want 0", i, stall_out); end
            n_cmp++; if (inst !== 32'hC0DE0100 + 32'(4 * i)) begin n_bad++; $display("FAIL sweep_inst[%0d]: got %h want %h", i, inst, 32'hC0DE0100 + 32'(4 * i)); end
            n_cmp++; if (hit_count !== 32'(1 + i)) begin n_bad++; $display("FAIL sweep_hit_count[%0d]: got %0d want %0d", i, hit_count, 1 + i); end
        end
        @(negedge clk); addr = 32'h140; #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL evict_stall: got %b want 1", stall_out); end
        n_cmp++; if (hit_count !== 32'd5) begin n_bad++; $display("FAIL sweep_hit_total: got %0d want 5", hit_count); end
        wait_fill(c);
        n_cmp++; if (c != 6) begin n_bad++; $display("FAIL evict_latency: got %0d want 6", c); end
        n_cmp++; if (inst !== 32'hC0DE0140) begin n_bad++; $display("FAIL evict_inst: got %h want C0DE0140", inst); end
        n_cmp++; if (miss_count !== 32'd2) begin n_bad++; $display("FAIL evict_miss_count: got %0d want 2", miss_count); end
        @(negedge clk); addr = 32'h100; #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL evicted_old_line: got %b want 1", stall_out); end
        wait_fill(c);
        n_cmp++; if (c != 6) begin n_bad++; $display("FAIL refill_latency: got %0d want 6", c); end
    endtask

    task automatic test_delays();
        int c;
        ar_delay = 3; r_gap = 1; sl_bad = 1'b0;
        @(negedge clk); addr = 32'h120; #1;
        wait_fill(c);
        n_cmp++; if (c != 13) begin n_bad++; $display("FAIL delayed_latency: got %0d want 13", c); end
        n_cmp++; if (sl_bad !== 1'b0) begin n_bad++; $display("FAIL ar_stable: got %b want 0", sl_bad); end
        ar_delay = 0; r_gap = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); addr = 32'h120 + 32'(4 * i); #1;
            n_cmp++; if (inst !== 32'hC0DE0120 + 32'(4 * i)) begin n_bad++; $display("FAIL delayed_word[%0d]: got %h want %h", i, inst, 32'hC0DE0120 + 32'(4 * i)); end
        end
    endtask

    task automatic test_error();
        int c;
        int errs;
        err_beat = 2; errs = 0;
        @(negedge clk); addr = 32'h130; #1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            if (fetch_err === 1'b1) errs++;
            if (k == 6) begin
                n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("FAIL err_pulse: got %b want 1", fetch_err); end
                n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL err_line_invalid: got %b want 1", stall_out); end
                err_beat = -1;
            end
            if (k == 7) begin
                n_cmp++; if (m_axi_arvalid !== 1'b1) begin n_bad++; $display("FAIL err_retry_arvalid: got %b want 1", m_axi_arvalid); end
                n_cmp++; if (m_axi_araddr !== 32'h130) begin n_bad++; $display("FAIL err_retry_araddr: got %h want 130", m_axi_araddr); end
            end
        end
        n_cmp++; if (errs != 1) begin n_bad++; $display("FAIL err_pulse_count: got %0d want 1", errs); end
        wait_fill(c);
        n_cmp++; if (c != 4) begin n_bad++; $display("FAIL err_retry_latency: got %0d want 4", c); end
        n_cmp++; if (inst !== 32'hC0DE0130) begin n_bad++; $display("FAIL err_retry_inst: got %h want C0DE0130", inst); end
        n_cmp++; if (miss_count !== 32'd6) begin n_bad++; $display("FAIL err_miss_count: got %0d want 6", miss_count); end
    endtask

    task automatic test_flush();
        int c;
        @(negedge clk); addr = 32'h200; #1;
        wait_fill(c);
        n_cmp++; if (c != 6) begin n_bad++; $display("FAIL fill_200_latency: got %0d want 6", c); end
        @(negedge clk); addr = 32'h110; #1;
        @(negedge clk); addr = 32'h120; #1;
        n_cmp++; if (stall_out !== 1'b0) begin n_bad++; $display("FAIL hit_during_refill_stall: got %b want 0", stall_out); end
        n_cmp++; if (inst !== 32'hC0DE0120) begin n_bad++; $display("FAIL hit_during_refill_inst: got %h want C0DE0120", inst); end
        @(negedge clk); flush = 1'b1; #1;
        n_cmp++; if (m_axi_rready !== 1'b1) begin n_bad++; $display("FAIL flush_in_r_rready: got %b want 1", m_axi_rready); end
        @(negedge clk); flush = 1'b0; #1;
        repeat (2) @(negedge clk);
        @(negedge clk); addr = 32'h110; #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL flushed_refill_valid: got %b want 1", stall_out); end
        n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL burst_done_idle: got %b want 0", m_axi_arvalid); end
        @(negedge clk); addr = 32'h200; #1;
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL flushed_200: got %b want 1", stall_out); end
        n_cmp++; if (m_axi_araddr !== 32'h110) begin n_bad++; $display("FAIL reissue_110_araddr: got %h want 110", m_axi_araddr); end
        wait_fill(c);
        n_cmp++; if (c != 11) begin n_bad++; $display("FAIL two_fill_latency: got %0d want 11", c); end
        @(negedge clk); addr = 32'h110; #1;
        n_cmp++; if (inst !== 32'hC0DE0110) begin n_bad++; $display("FAIL refilled_110: got %h want C0DE0110", inst); end
        @(negedge clk); addr = 32'h300; flush = 1'b1; #1;
        @(negedge clk); addr = 32'h110; flush = 1'b0; #1;
        n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL flush_wins_arvalid: got %b want 0", m_axi_arvalid); end
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL idle_flush_cleared: got %b want 1", stall_out); end
        @(negedge clk); #1;
        n_cmp++; if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== 32'h110) begin n_bad++; $display("FAIL post_flush_ar: got %b/%h want 1/110", m_axi_arvalid, m_axi_araddr); end
        wait_fill(c);
        n_cmp++; if (c != 5) begin n_bad++; $display("FAIL post_flush_fill: got %0d want 5", c); end
    endtask

    task automatic test_reset_mid();
        int c;
        @(negedge clk); addr = 32'h140; #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++; if (m_axi_rready !== 1'b1) begin n_bad++; $display("FAIL mid_in_r: got %b want 1", m_axi_rready); end
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; addr = 32'h110; #1;
        n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_arvalid: got %b want 0", m_axi_arvalid); end
        n_cmp++; if (m_axi_rready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rready: got %b want 0", m_axi_rready); end
        n_cmp++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_bad++; $display("FAIL mid_rst_counters: got %0d/%0d want 0/0", hit_count, miss_count); end
        n_cmp++; if (stall_out !== 1'b1) begin n_bad++; $display("FAIL mid_rst_first_miss: got %b want 1", stall_out); end
        wait_fill(c);
        n_cmp++; if (c != 6) begin n_bad++; $display("FAIL mid_rst_refill: got %0d want 6", c); end
        n_cmp++; if (miss_count !== 32'd1) begin n_bad++; $display("FAIL mid_rst_miss_count: got %0d want 1", miss_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_miss();
        test_hit_sweep();
        test_delays();
        test_error();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
